// File: rtl/aon_wkup_rst_collector.sv
`default_nettype none
// ============================================================================
// Module   : aon_wkup_rst_collector
// Summary  : Filters AON wakeup/reset requests, latches sticky causes and
//            sequences low-power entry/exit (ACTIVE/FALL/SLEEP/RISE).
//            Optional input filters enabled by macro AON_WKUP_FILTER_EN.
// Revision : 1.0 - initial release
// ============================================================================
module aon_wkup_rst_collector #(
  parameter int unsigned NumWkups     = 2,
  parameter int unsigned NumRstReqs   = 2,
  parameter int unsigned FilterCycles = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [NumWkups-1:0]   wkup_req_i,
  input  logic [NumWkups-1:0]   wkup_en_i,
  input  logic [NumRstReqs-1:0] rst_req_i,
  input  logic [NumRstReqs-1:0] rst_en_i,
  input  logic                  low_power_req_i,
  input  logic                  wkup_cause_clr_i,
  output logic                  sleep_mode_o,
  output logic                  wkup_o,
  output logic                  abort_o,
  output logic [NumWkups-1:0]   wkup_cause_o,
  output logic                  rst_req_o,
  output logic [NumRstReqs-1:0] rst_cause_o
);

  localparam logic [1:0] StActive = 2'd0;
  localparam logic [1:0] StFall   = 2'd1;
  localparam logic [1:0] StSleep  = 2'd2;
  localparam logic [1:0] StRise   = 2'd3;

  logic [NumWkups-1:0]   filt_wkup;
  logic [NumRstReqs-1:0] filt_rst;

`ifdef AON_WKUP_FILTER_EN
  localparam int unsigned     CntW    = $clog2(FilterCycles + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(FilterCycles - 1);

  for (genvar i = 0; i < NumWkups; i++) begin : g_wkup_filt
    logic            filt_q, filt_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    // Counter tracks consecutive cycles the raw input disagrees with filt.
    always_comb begin
      filt_d = filt_q;
      cnt_d  = '0;
      if (wkup_req_i[i] != filt_q) begin
        if (cnt_q == CntLast) begin
          filt_d = wkup_req_i[i];
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        filt_q <= 1'b0;
        cnt_q  <= '0;
      end else begin
        filt_q <= filt_d;
        cnt_q  <= cnt_d;
      end
    end

    assign filt_wkup[i] = filt_q;
  end

  for (genvar i = 0; i < NumRstReqs; i++) begin : g_rst_filt
    logic            filt_q, filt_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
      filt_d = filt_q;
      cnt_d  = '0;
      if (rst_req_i[i] != filt_q) begin
        if (cnt_q == CntLast) begin
          filt_d = rst_req_i[i];
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        filt_q <= 1'b0;
        cnt_q  <= '0;
      end else begin
        filt_q <= filt_d;
        cnt_q  <= cnt_d;
      end
    end

    assign filt_rst[i] = filt_q;
  end
`else
  logic unused_filter_cfg;
  assign unused_filter_cfg = (FilterCycles != 0);
  assign filt_wkup = wkup_req_i;
  assign filt_rst  = rst_req_i;
`endif

  logic [NumWkups-1:0]   wk_hits;
  logic [NumRstReqs-1:0] rs_hits;
  logic                  pend;

  assign wk_hits = filt_wkup & wkup_en_i;
  assign rs_hits = filt_rst & rst_en_i;
  assign pend    = (|wk_hits) | (|rs_hits);

  logic [1:0] state_q, state_d;
  logic       abort_q, abort_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StActive;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      abort_q <= abort_d;
    end
  end

  always_comb begin
    state_d = state_q;
    abort_d = 1'b0;
    case (state_q)
      StActive: if (low_power_req_i) state_d = StFall;
      StFall: begin
        if (pend) begin
          state_d = StActive;
          abort_d = 1'b1;
        end else begin
          state_d = StSleep;
        end
      end
      StSleep:  if (pend) state_d = StRise;
      StRise:   state_d = StActive;
      default:  state_d = StActive;
    endcase
  end

  always_comb begin
    sleep_mode_o = (state_q == StSleep);
    wkup_o       = (state_q == StRise);
    abort_o      = abort_q;
  end

  logic [NumWkups-1:0]   wkup_cause_q, wkup_cause_d;
  logic [NumRstReqs-1:0] rst_cause_q, rst_cause_d;
  logic                  rst_req_q;

  // A set in the same cycle as a clear wins for that bit.
  always_comb begin
    wkup_cause_d = wkup_cause_clr_i ? '0 : wkup_cause_q;
    if ((state_q == StFall) || (state_q == StSleep)) begin
      wkup_cause_d = wkup_cause_d | wk_hits;
    end
    rst_cause_d = rst_cause_q | rs_hits;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wkup_cause_q <= '0;
      rst_cause_q  <= '0;
      rst_req_q    <= 1'b0;
    end else begin
      wkup_cause_q <= wkup_cause_d;
      rst_cause_q  <= rst_cause_d;
      rst_req_q    <= |rst_cause_d;
    end
  end

  assign wkup_cause_o = wkup_cause_q;
  assign rst_cause_o  = rst_cause_q;
  assign rst_req_o    = rst_req_q;

endmodule
`default_nettype wire

// File: tb/tb_aon_wkup_rst_collector.sv
`default_nettype none
// ============================================================================
// Module   : tb_aon_wkup_rst_collector
// Summary  : Directed bench with a window-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_aon_wkup_rst_collector;

  localparam int N = 3;
`ifdef AON_WKUP_FILTER_EN
  localparam int L = N + 1;
`else
  localparam int L = 1;
`endif

  localparam logic [1:0] P_ACT = 2'd0, P_FALL = 2'd1, P_SLEEP = 2'd2, P_RISE = 2'd3;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic [1:0] wkup_req_i, wkup_en_i, rst_req_i, rst_en_i;
  logic       low_power_req_i, wkup_cause_clr_i;
  logic       sleep_mode_o, wkup_o, abort_o, rst_req_o;
  logic [1:0] wkup_cause_o, rst_cause_o;

  always #5 clk_i = ~clk_i;

  aon_wkup_rst_collector #(
    .NumWkups(2), .NumRstReqs(2), .FilterCycles(N)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .wkup_req_i(wkup_req_i), .wkup_en_i(wkup_en_i),
    .rst_req_i(rst_req_i), .rst_en_i(rst_en_i),
    .low_power_req_i(low_power_req_i), .wkup_cause_clr_i(wkup_cause_clr_i),
    .sleep_mode_o(sleep_mode_o), .wkup_o(wkup_o), .abort_o(abort_o),
    .wkup_cause_o(wkup_cause_o), .rst_req_o(rst_req_o), .rst_cause_o(rst_cause_o)
  );

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a filtered bit follows the raw input once the last N samples agree.
  typedef struct packed {
    logic [1:0]        ph;
    logic              ab;
    logic [1:0]        wc;
    logic              rq;
    logic [1:0]        rc;
    logic [1:0]        fw;
    logic [1:0]        fr;
    logic [1:0][N-1:0] hw;
    logic [1:0][N-1:0] hr;
  } ms_t;

  ms_t m;

  function automatic ms_t mstep(input ms_t s, input logic [1:0] wr, input logic [1:0] we,
                                input logic [1:0] rr, input logic [1:0] re,
                                input logic lp, input logic clr);
    ms_t n;
    logic [1:0] pw, pr;
    logic       any;
    n = s;
`ifdef AON_WKUP_FILTER_EN
    pw = s.fw;
    pr = s.fr;
`else
    pw = wr;
    pr = rr;
`endif
    any = (|(pw & we)) | (|(pr & re));
    for (int b = 0; b < 2; b++) begin
      n.hw[b] = {s.hw[b][N-2:0], wr[b]};
      n.hr[b] = {s.hr[b][N-2:0], rr[b]};
      n.fw[b] = (&n.hw[b]) ? 1'b1 : ((|n.hw[b]) ? s.fw[b] : 1'b0);
      n.fr[b] = (&n.hr[b]) ? 1'b1 : ((|n.hr[b]) ? s.fr[b] : 1'b0);
    end
    n.ab = 1'b0;
    case (s.ph)
      P_ACT:   n.ph = lp ? P_FALL : P_ACT;
      P_FALL:  begin n.ph = any ? P_ACT : P_SLEEP; n.ab = any; end
      P_SLEEP: n.ph = any ? P_RISE : P_SLEEP;
      default: n.ph = P_ACT;
    endcase
    n.wc = clr ? 2'b00 : s.wc;
    if (s.ph == P_FALL || s.ph == P_SLEEP) n.wc = n.wc | (pw & we);
    n.rc = s.rc | (pr & re);
    n.rq = |n.rc;
    return n;
  endfunction

  always @(posedge clk_i) begin
    if (rst_i) m <= '0;
    else m <= mstep(m, wkup_req_i, wkup_en_i, rst_req_i, rst_en_i, low_power_req_i, wkup_cause_clr_i);
  end

  bit chk_en = 1'b0;
  int wk_cnt = 0, ab_cnt = 0, sl_cnt = 0;

  always @(posedge clk_i) begin
    #1;
    if (chk_en) begin
      chk("cyc_sleep_mode", sleep_mode_o, m.ph == P_SLEEP);
      chk("cyc_wkup", wkup_o, m.ph == P_RISE);
      chk("cyc_abort", abort_o, m.ab);
      chk("cyc_wkup_cause", wkup_cause_o, m.wc);
      chk("cyc_rst_req", rst_req_o, m.rq);
      chk("cyc_rst_cause", rst_cause_o, m.rc);
      if (wkup_o) wk_cnt++;
      if (abort_o) ab_cnt++;
      if (sleep_mode_o) sl_cnt++;
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  task automatic enter_sleep();
    low_power_req_i = 1'b1;
    step(1);
    low_power_req_i = 1'b0;
    step(1);
  endtask

  int w0, a0, s0;

  initial begin
    rst_i = 1'b1;
    wkup_req_i = '0; wkup_en_i = '0; rst_req_i = '0; rst_en_i = '0;
    low_power_req_i = 1'b0; wkup_cause_clr_i = 1'b0;
    step(2);
    chk_en = 1'b1;
    chk("reset_outputs", {sleep_mode_o, wkup_o, abort_o, wkup_cause_o, rst_req_o, rst_cause_o}, 0);
    rst_i = 1'b0;

    // Entry/exit
    wkup_en_i = 2'b01;
    low_power_req_i = 1'b1;
    step(1);
    low_power_req_i = 1'b0;
    chk("t1_fall_not_sleep", sleep_mode_o, 1'b0);
    step(1);
    chk("t1_sleep", sleep_mode_o, 1'b1);
    w0 = wk_cnt;
    wkup_req_i = 2'b01;
    step(L - 1);
    chk("t1_latency_still_sleep", {sleep_mode_o, wkup_o}, 2'b10);
    step(1);
    chk("t1_rise", {sleep_mode_o, wkup_o}, 2'b01);
    step(5 - L);
    wkup_req_i = 2'b00;
    step(1);
    chk("t1_cause", wkup_cause_o, 2'b01);
    chk("t1_back_active", {sleep_mode_o, wkup_o}, 2'b00);
    chk("t1_one_wkup", wk_cnt - w0, 1);
    step(N + 2);

    // Glitch reject
    wkup_cause_clr_i = 1'b1;
    step(1);
    wkup_cause_clr_i = 1'b0;
    chk("t2_cleared", wkup_cause_o, 2'b00);
    enter_sleep();
    w0 = wk_cnt;
    wkup_req_i = 2'b01;
    step(2);
    wkup_req_i = 2'b00;
    step(4);
`ifdef AON_WKUP_FILTER_EN
    chk("t2_glitch_sleep", sleep_mode_o, 1'b1);
    chk("t2_glitch_cause", wkup_cause_o, 2'b00);
    chk("t2_glitch_nowkup", wk_cnt - w0, 0);
`else
    chk("t2_raw_woke", sleep_mode_o, 1'b0);
    chk("t2_raw_cause", wkup_cause_o, 2'b01);
    chk("t2_raw_wkup", wk_cnt - w0, 1);
`endif

    // Synchronous reset mid-SLEEP (filter build) / in ACTIVE (raw build)
    w0 = wk_cnt;
    rst_i = 1'b1;
    step(1);
    rst_i = 1'b0;
    chk("t6_reset_outputs", {sleep_mode_o, wkup_o, abort_o, wkup_cause_o, rst_req_o, rst_cause_o}, 0);
    step(2);
    chk("t6_no_wkup", wk_cnt - w0, 0);

    // Abort
    wkup_en_i = 2'b10;
    wkup_req_i = 2'b10;
    step(N + 1);
    a0 = ab_cnt;
    s0 = sl_cnt;
    low_power_req_i = 1'b1;
    step(1);
    low_power_req_i = 1'b0;
    step(1);
    chk("t3_abort", abort_o, 1'b1);
    chk("t3_cause", wkup_cause_o, 2'b10);
    step(1);
    chk("t3_abort_once", {abort_o, 32'(ab_cnt - a0)}, {1'b0, 32'd1});
    chk("t3_never_sleep", sl_cnt - s0, 0);
    wkup_req_i = 2'b00;
    wkup_cause_clr_i = 1'b1;
    step(1);
    wkup_cause_clr_i = 1'b0;
    step(N + 1);

    // Held low_power_req with a pending wake keeps re-entering FALL
    wkup_en_i = 2'b01;
    wkup_req_i = 2'b01;
    step(N + 1);
    a0 = ab_cnt;
    low_power_req_i = 1'b1;
    step(6);
    low_power_req_i = 1'b0;
    chk("held_lpr_aborts", ab_cnt - a0, 3);
    wkup_req_i = 2'b00;
    wkup_cause_clr_i = 1'b1;
    step(1);
    wkup_cause_clr_i = 1'b0;
    step(N + 2);

    // Reset request
    wkup_en_i = 2'b00;
    rst_en_i = 2'b01;
    enter_sleep();
    chk("t4_sleep", sleep_mode_o, 1'b1);
    w0 = wk_cnt;
    rst_req_i = 2'b01;
    step(N + 2);
    chk("t4_rst_req", rst_req_o, 1'b1);
    chk("t4_rst_cause", rst_cause_o, 2'b01);
    chk("t4_wkup_cause", wkup_cause_o, 2'b00);
    chk("t4_rise", wk_cnt - w0, 1);
    rst_req_i = 2'b00;
    step(N + 3);
    chk("t4_sticky", {rst_req_o, rst_cause_o}, 3'b101);
    rst_i = 1'b1;
    step(1);
    rst_i = 1'b0;
    chk("t4_cleared_by_rst", {rst_req_o, rst_cause_o}, 3'b000);

    // Mask / clear
    rst_en_i = 2'b00;
    wkup_req_i = 2'b11;
    enter_sleep();
    step(N + 3);
    chk("t5_masked_sleep", sleep_mode_o, 1'b1);
    chk("t5_masked_cause", wkup_cause_o, 2'b00);
    wkup_en_i = 2'b01;
    wkup_cause_clr_i = 1'b1;
    step(1);
    wkup_cause_clr_i = 1'b0;
    chk("t5_set_beats_clr", wkup_cause_o, 2'b01);
    chk("t5_rise", wkup_o, 1'b1);
    wkup_cause_clr_i = 1'b1;
    step(1);
    wkup_cause_clr_i = 1'b0;
    chk("t5_clr_alone", wkup_cause_o, 2'b00);
    wkup_req_i = 2'b00;
    step(N + 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected end before 200000");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
